// File: rtl/fpu_mem_responder.sv
// fpu_mem_responder
//   Memory-side responder for FPU buffer transfers. A drain request copies the
//   idle write buffer out to system memory; a fill request loads the idle read
//   buffer from system memory. When both are requested together, the drain runs
//   first. o_making_request stalls the FPU controller while a transfer runs.
//
// Ports
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_request_read/_write     fill / drain requests, sampled only in IDLE
//   i_read_address            memory byte address of fill row 0, col 0
//   i_write_address           memory byte address of drain row 0, col 0
//   i_write_request_width     bytes per drained row
//   i_write_request_height    rows to drain
//   i_rd_buffer_sel           buffer in use by the FPU (the other one is targeted)
//   i_image_width             image width in pixels, used for memory strides
//   o_making_request          transfer in progress
//   o_mem_* / i_mem_*         byte-wide memory port, one outstanding access
//   o_rb_*                    read-buffer byte write port
//   o_wb_rd_* / i_wb_rd_data  write-buffer read port, data one cycle after index
//
// States
//   IDLE   | waiting for a request
//   E_RD   | present write-buffer index for the next drain byte
//   E_WR   | memory write of the drain byte, held until granted
//   F_REQ  | memory read request for the next fill byte
//   F_WAIT | waiting for read data, then write it into the read buffer
//   DONE   | one idle cycle with requests ignored, then IDLE

module fpu_mem_responder #(
    parameter int  COL_WIDTH        = 10,
    parameter int  MEM_BUFFER_WIDTH = 512,
    localparam int CW               = $clog2(MEM_BUFFER_WIDTH),
    localparam int RW               = $clog2(COL_WIDTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_request_read,
    input  logic          i_request_write,
    input  logic [31:0]   i_read_address,
    input  logic [31:0]   i_write_address,
    input  logic [16:0]   i_write_request_width,
    input  logic [8:0]    i_write_request_height,
    input  logic          i_rd_buffer_sel,
    input  logic [15:0]   i_image_width,
    output logic          o_making_request,
    output logic          o_mem_req,
    output logic          o_mem_we,
    output logic [31:0]   o_mem_addr,
    output logic [7:0]    o_mem_wdata,
    input  logic          i_mem_gnt,
    input  logic          i_mem_rvalid,
    input  logic [7:0]    i_mem_rdata,
    output logic          o_rb_wr_en,
    output logic          o_rb_wr_sel,
    output logic [RW-1:0] o_rb_row,
    output logic [CW-1:0] o_rb_col,
    output logic [7:0]    o_rb_wr_data,
    output logic          o_wb_rd_sel,
    output logic [RW-1:0] o_wb_rd_row,
    output logic [CW-1:0] o_wb_rd_col,
    input  logic [7:0]    i_wb_rd_data
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        E_RD   = 3'd1,
        E_WR   = 3'd2,
        F_REQ  = 3'd3,
        F_WAIT = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [16:0]   MAX_W         = 17'(MEM_BUFFER_WIDTH);
    localparam logic [8:0]    MAX_H         = 9'(COL_WIDTH);
    localparam logic [RW-1:0] FILL_LAST_ROW = RW'(COL_WIDTH - 1);
    localparam logic [CW-1:0] FILL_LAST_COL = CW'(MEM_BUFFER_WIDTH - 1);

    state_t        r_state;
    state_t        w_next_state;

    logic          r_sel;
    logic          r_fill_pend;
    logic          r_drain_empty;
    logic [31:0]   r_rd_addr;
    logic [31:0]   r_wr_addr;
    logic [31:0]   r_si;
    logic [31:0]   r_so;
    logic [16:0]   r_last_col;
    logic [8:0]    r_last_row;
    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic [7:0]    r_wdata;
    logic          r_wd_held;

    logic          w_accept;
    logic [16:0]   w_eff_w;
    logic [8:0]    w_eff_h;
    logic [31:0]   w_si;
    logic [31:0]   w_so;
    logic          w_drain_col_last;
    logic          w_drain_last;
    logic          w_fill_col_last;
    logic          w_fill_last;
    logic [31:0]   w_wr_byte_addr;
    logic [31:0]   w_rd_byte_addr;
    logic [7:0]    w_wdata;

    assign w_accept = i_request_read | i_request_write;
    assign w_eff_w  = (i_write_request_width > MAX_W) ? MAX_W : i_write_request_width;
    assign w_eff_h  = (i_write_request_height > MAX_H) ? MAX_H : i_write_request_height;
    assign w_si     = (32'(i_image_width) + 32'd2) * 32'd3;
    assign w_so     = 32'(i_image_width) * 32'd3 + 32'd4;

    assign w_drain_col_last = (17'(r_col) == r_last_col);
    assign w_drain_last     = w_drain_col_last && (9'(r_row) == r_last_row);
    assign w_fill_col_last  = (r_col == FILL_LAST_COL);
    assign w_fill_last      = w_fill_col_last && (r_row == FILL_LAST_ROW);

    assign w_wr_byte_addr = r_wr_addr + 32'(r_row) * r_so + 32'(r_col);
    assign w_rd_byte_addr = r_rd_addr + 32'(r_row) * r_si + 32'(r_col);

    // The write-buffer data is only valid in the first E_WR cycle; after that
    // the captured copy keeps mem_wdata stable while the grant is stalled.
    assign w_wdata = r_wd_held ? r_wdata : i_wb_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state     = r_state;
        o_making_request = 1'b0;
        o_mem_req        = 1'b0;
        o_mem_we         = 1'b0;
        o_mem_addr       = 32'd0;
        o_mem_wdata      = 8'd0;
        o_rb_wr_en       = 1'b0;
        o_rb_wr_sel      = 1'b0;
        o_rb_row         = '0;
        o_rb_col         = '0;
        o_rb_wr_data     = 8'd0;
        o_wb_rd_sel      = 1'b0;
        o_wb_rd_row      = '0;
        o_wb_rd_col      = '0;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = i_request_write ? E_RD : F_REQ;
                end
            end
            E_RD: begin
                o_making_request = 1'b1;
                if (r_drain_empty) begin
                    // empty drain still holds making_request for this one cycle
                    w_next_state = r_fill_pend ? F_REQ : DONE;
                end else begin
                    o_wb_rd_sel  = r_sel;
                    o_wb_rd_row  = r_row;
                    o_wb_rd_col  = r_col;
                    w_next_state = E_WR;
                end
            end
            E_WR: begin
                o_making_request = 1'b1;
                o_mem_req        = 1'b1;
                o_mem_we         = 1'b1;
                o_mem_addr       = w_wr_byte_addr;
                o_mem_wdata      = w_wdata;
                if (i_mem_gnt) begin
                    if (w_drain_last) begin
                        w_next_state = r_fill_pend ? F_REQ : DONE;
                    end else begin
                        w_next_state = E_RD;
                    end
                end
            end
            F_REQ: begin
                o_making_request = 1'b1;
                o_mem_req        = 1'b1;
                o_mem_addr       = w_rd_byte_addr;
                if (i_mem_gnt) begin
                    w_next_state = F_WAIT;
                end
            end
            F_WAIT: begin
                o_making_request = 1'b1;
                if (i_mem_rvalid) begin
                    o_rb_wr_en   = 1'b1;
                    o_rb_wr_sel  = r_sel;
                    o_rb_row     = r_row;
                    o_rb_col     = r_col;
                    o_rb_wr_data = i_mem_rdata;
                    w_next_state = w_fill_last ? DONE : F_REQ;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sel         <= 1'b0;
            r_fill_pend   <= 1'b0;
            r_drain_empty <= 1'b0;
            r_rd_addr     <= 32'd0;
            r_wr_addr     <= 32'd0;
            r_si          <= 32'd0;
            r_so          <= 32'd0;
            r_last_col    <= 17'd0;
            r_last_row    <= 9'd0;
            r_row         <= '0;
            r_col         <= '0;
            r_wdata       <= 8'd0;
            r_wd_held     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_sel         <= ~i_rd_buffer_sel;
                        r_fill_pend   <= i_request_read;
                        r_drain_empty <= (w_eff_w == 17'd0) || (w_eff_h == 9'd0);
                        r_rd_addr     <= i_read_address;
                        r_wr_addr     <= i_write_address;
                        r_si          <= w_si;
                        r_so          <= w_so;
                        r_last_col    <= w_eff_w - 17'd1;
                        r_last_row    <= w_eff_h - 9'd1;
                        r_row         <= '0;
                        r_col         <= '0;
                        r_wd_held     <= 1'b0;
                    end
                end
                E_RD: begin
                    r_wd_held <= 1'b0;
                end
                E_WR: begin
                    r_wdata   <= w_wdata;
                    r_wd_held <= 1'b1;
                    if (i_mem_gnt) begin
                        r_wd_held <= 1'b0;
                        if (w_drain_last) begin
                            // fill starts from row 0, col 0
                            r_row <= '0;
                            r_col <= '0;
                        end else if (w_drain_col_last) begin
                            r_col <= '0;
                            r_row <= r_row + RW'(1);
                        end else begin
                            r_col <= r_col + CW'(1);
                        end
                    end
                end
                F_WAIT: begin
                    if (i_mem_rvalid) begin
                        if (w_fill_col_last) begin
                            r_col <= '0;
                            r_row <= r_row + RW'(1);
                        end else begin
                            r_col <= r_col + CW'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_mem_responder.sv
// tb_fpu_mem_responder
//   Directed bench for fpu_mem_responder with a 3-row x 4-byte buffer geometry.
//   Expected memory accesses and read-buffer writes are queued before each
//   request; a monitor pops and compares them as the DUT produces them.

module tb_fpu_mem_responder;

    localparam int COLW = 3;
    localparam int MBW  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        request_read = 1'b0;
    logic        request_write = 1'b0;
    logic [31:0] read_address = 32'h0;
    logic [31:0] write_address = 32'h0;
    logic [16:0] write_request_width = 17'd0;
    logic [8:0]  write_request_height = 9'd0;
    logic        rd_buffer_sel = 1'b0;
    logic [15:0] image_width = 16'd2;
    logic        making_request;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [7:0]  mem_rdata = 8'h0;
    logic        rb_wr_en;
    logic        rb_wr_sel;
    logic [1:0]  rb_row;
    logic [1:0]  rb_col;
    logic [7:0]  rb_wr_data;
    logic        wb_rd_sel;
    logic [1:0]  wb_rd_row;
    logic [1:0]  wb_rd_col;
    logic [7:0]  wb_rd_data = 8'h0;

    fpu_mem_responder #(.COL_WIDTH(COLW), .MEM_BUFFER_WIDTH(MBW)) dut (
        .i_clk                  (clk),
        .i_rst                  (rst),
        .i_request_read         (request_read),
        .i_request_write        (request_write),
        .i_read_address         (read_address),
        .i_write_address        (write_address),
        .i_write_request_width  (write_request_width),
        .i_write_request_height (write_request_height),
        .i_rd_buffer_sel        (rd_buffer_sel),
        .i_image_width          (image_width),
        .o_making_request       (making_request),
        .o_mem_req              (mem_req),
        .o_mem_we               (mem_we),
        .o_mem_addr             (mem_addr),
        .o_mem_wdata            (mem_wdata),
        .i_mem_gnt              (mem_gnt),
        .i_mem_rvalid           (mem_rvalid),
        .i_mem_rdata            (mem_rdata),
        .o_rb_wr_en             (rb_wr_en),
        .o_rb_wr_sel            (rb_wr_sel),
        .o_rb_row               (rb_row),
        .o_rb_col               (rb_col),
        .o_rb_wr_data           (rb_wr_data),
        .o_wb_rd_sel            (wb_rd_sel),
        .o_wb_rd_row            (wb_rd_row),
        .o_wb_rd_col            (wb_rd_col),
        .i_wb_rd_data           (wb_rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [7:0]  data;
    } mem_exp_t;

    typedef struct {
        logic       sel;
        logic [1:0] row;
        logic [1:0] col;
        logic [7:0] data;
    } rb_exp_t;

    mem_exp_t exp_mem[$];
    rb_exp_t  exp_rb[$];

    int checks = 0;
    int errors = 0;

    logic [7:0] sysmem [0:1023];

    // memory model / monitor state
    logic        mon_en = 1'b0;
    logic        stall_en = 1'b0;
    logic        stalling = 1'b0;
    int          stall_left = 0;
    logic        rd_pend = 1'b0;
    logic [7:0]  rd_pend_data = 8'h0;
    logic        hold_chk = 1'b0;
    logic [41:0] hold_val = '0;
    logic        mr_prev = 1'b0;
    int          mr_cycles = 0;
    int          mr_rises = 0;
    int          req_cycles = 0;

    function automatic logic [7:0] wb_val(input logic b, input logic [1:0] r, input logic [1:0] c);
        return {b, 3'b001, r, c};
    endfunction

    function automatic logic [7:0] pat(input logic [31:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // write buffer: synchronous read, data one cycle after the index
    always @(posedge clk) begin
        wb_rd_data <= wb_val(wb_rd_sel, wb_rd_row, wb_rd_col);
    end

    always @(negedge clk) begin
        mem_rvalid = rd_pend;
        mem_rdata  = rd_pend_data;
        rd_pend    = 1'b0;
        mem_gnt    = 1'b0;
        if (rst) stalling = 1'b0;
        if (mon_en && mem_req) begin
            if (!stalling) begin
                stall_left = stall_en ? int'($urandom_range(0, 20)) : 0;
                stalling   = 1'b1;
            end
            if (stall_left == 0) begin
                mem_gnt  = 1'b1;
                stalling = 1'b0;
                if (mem_we) begin
                    sysmem[mem_addr[9:0]] = mem_wdata;
                end else begin
                    rd_pend      = 1'b1;
                    rd_pend_data = sysmem[mem_addr[9:0]];
                end
            end else begin
                stall_left--;
            end
        end
        #1;
        if (mon_en) begin
            if (making_request) mr_cycles++;
            if (making_request && !mr_prev) mr_rises++;
            mr_prev = making_request;
            if (mem_req) req_cycles++;
            if (hold_chk && !rst) begin
                chk("mem_hold", {mem_req, mem_we, mem_addr, mem_wdata}, hold_val);
            end
            if (mem_req && mem_gnt) begin
                if (exp_mem.size() == 0) begin
                    chk("mem_unexpected", {mem_we, mem_addr}, 33'h0);
                    if (mem_we == 1'b0 && mem_addr == 32'h0) begin
                        errors++;
                        $display("FAIL mem_unexpected: got access at 0 expected none");
                    end
                end else begin
                    mem_exp_t e;
                    e = exp_mem.pop_front();
                    chk("mem_access", {mem_we, mem_addr, (mem_we ? mem_wdata : 8'h0)},
                        {e.we, e.addr, e.data});
                end
            end
            hold_chk = mem_req && !mem_gnt && !rst;
            hold_val = {mem_req, mem_we, mem_addr, mem_wdata};
            if (rb_wr_en) begin
                if (exp_rb.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL rb_unexpected: got row %0d col %0d expected no write", rb_row, rb_col);
                end else begin
                    rb_exp_t r;
                    r = exp_rb.pop_front();
                    chk("rb_write", {rb_wr_sel, rb_row, rb_col, rb_wr_data},
                        {r.sel, r.row, r.col, r.data});
                end
            end
        end
    end

    task automatic push_fill(input logic [31:0] base, input int iw, input logic sel);
        for (int r = 0; r < COLW; r++) begin
            for (int c = 0; c < MBW; c++) begin
                logic [31:0] a;
                a = base + 32'(r * (iw + 2) * 3 + c);
                exp_mem.push_back('{we: 1'b0, addr: a, data: 8'h0});
                exp_rb.push_back('{sel: sel, row: 2'(r), col: 2'(c), data: pat(a)});
            end
        end
    endtask

    task automatic push_drain(input logic [31:0] base, input int iw, input int w, input int h,
                              input logic bsel);
        int ew;
        int eh;
        ew = (w > MBW) ? MBW : w;
        eh = (h > COLW) ? COLW : h;
        for (int r = 0; r < eh; r++) begin
            for (int c = 0; c < ew; c++) begin
                exp_mem.push_back('{we: 1'b1, addr: base + 32'(r * (iw * 3 + 4) + c),
                                    data: wb_val(bsel, 2'(r), 2'(c))});
            end
        end
    endtask

    task automatic start(input logic rd, input logic wr);
        @(negedge clk); #2;
        request_read  = rd;
        request_write = wr;
        @(negedge clk); #2;
        request_read  = 1'b0;
        request_write = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (making_request !== 1'b0 && n < budget) begin
            @(negedge clk); #2;
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL timeout: making_request still %b after %0d cycles expected 0", making_request, n);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); #2;
        end
    endtask

    task automatic clear_drain_area(input logic [31:0] base);
        for (int i = 0; i < 24; i++) sysmem[10'(base) + 10'(i)] = 8'h00;
    endtask

    task automatic check_drain_image;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 3; c++) begin
                chk("mem_image", {24'h0, sysmem[10'h040 + 10'(r * 10 + c)]}, {24'h0, wb_val(1'b0, 2'(r), 2'(c))});
            end
        end
        chk("mem_image_col3", {24'h0, sysmem[10'h043]}, 32'h0);
        chk("mem_image_row2", {24'h0, sysmem[10'h054]}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int mr0;
        int rise0;
        int req0;

        for (int i = 0; i < 1024; i++) sysmem[i] = pat(32'(i));

        // reset state
        idle_cycles(3);
        chk("reset_outputs",
            {making_request, mem_req, mem_we, mem_addr, mem_wdata, rb_wr_en, rb_wr_sel,
             rb_row, rb_col, rb_wr_data, wb_rd_sel, wb_rd_row, wb_rd_col}, 64'h0);
        rst = 1'b0;
        mon_en = 1'b1;
        idle_cycles(2);

        // fill only; sel and requests toggled mid-transfer must not matter
        read_address  = 32'h100;
        image_width   = 16'd2;
        rd_buffer_sel = 1'b0;
        push_fill(32'h100, 2, 1'b1);
        mr0 = mr_cycles; rise0 = mr_rises;
        start(1'b1, 1'b0);
        idle_cycles(3);
        rd_buffer_sel = 1'b1;
        request_write = 1'b1;
        idle_cycles(2);
        request_write = 1'b0;
        wait_done(200);
        chk("fill_mr_cycles", 64'(mr_cycles - mr0), 64'd24);
        chk("fill_mr_rises", 64'(mr_rises - rise0), 64'd1);
        chk("fill_queue_empty", 64'(exp_mem.size() + exp_rb.size()), 64'd0);
        idle_cycles(1);
        chk("fill_idle_after_done", {63'h0, making_request}, 64'h0);
        idle_cycles(2);

        // drain only: buffer 0, 3 x 2 bytes
        write_address        = 32'h40;
        write_request_width  = 17'd3;
        write_request_height = 9'd2;
        rd_buffer_sel        = 1'b1;
        clear_drain_area(32'h40);
        push_drain(32'h40, 2, 3, 2, 1'b0);
        mr0 = mr_cycles;
        start(1'b0, 1'b1);
        wait_done(200);
        chk("drain_mr_cycles", 64'(mr_cycles - mr0), 64'd12);
        chk("drain_queue_empty", 64'(exp_mem.size()), 64'd0);
        check_drain_image();
        idle_cycles(2);

        // both: drain then fill with making_request continuous
        clear_drain_area(32'h40);
        push_drain(32'h40, 2, 3, 2, 1'b0);
        push_fill(32'h100, 2, 1'b0);
        mr0 = mr_cycles; rise0 = mr_rises;
        start(1'b1, 1'b1);
        wait_done(300);
        chk("both_mr_cycles", 64'(mr_cycles - mr0), 64'd36);
        chk("both_mr_rises", 64'(mr_rises - rise0), 64'd1);
        chk("both_queue_empty", 64'(exp_mem.size() + exp_rb.size()), 64'd0);
        idle_cycles(2);

        // zero-width drain: no memory traffic, one cycle of making_request
        write_request_width  = 17'd0;
        write_request_height = 9'd5;
        mr0 = mr_cycles; req0 = req_cycles;
        start(1'b0, 1'b1);
        wait_done(20);
        chk("zero_mr_cycles", 64'(mr_cycles - mr0), 64'd1);
        chk("zero_mem_req", 64'(req_cycles - req0), 64'd0);
        idle_cycles(2);
        chk("zero_back_idle", {63'h0, making_request}, 64'h0);

        // oversize drain clamps to 4 x 3
        write_address        = 32'h200;
        write_request_width  = 17'd9;
        write_request_height = 9'd7;
        push_drain(32'h200, 2, 9, 7, 1'b0);
        mr0 = mr_cycles;
        start(1'b0, 1'b1);
        wait_done(200);
        chk("clamp_mr_cycles", 64'(mr_cycles - mr0), 64'd24);
        chk("clamp_queue_empty", 64'(exp_mem.size()), 64'd0);
        idle_cycles(2);

        // reset in the 5th cycle of a fill
        rd_buffer_sel = 1'b0;
        push_fill(32'h100, 2, 1'b1);
        mr0 = mr_cycles;
        start(1'b1, 1'b0);
        begin
            int n;
            n = 0;
            while ((mr_cycles - mr0) < 5 && n < 50) begin
                @(negedge clk); #2;
                n++;
            end
            chk("rst_reached_cycle5", 64'(mr_cycles - mr0), 64'd5);
        end
        rst = 1'b1;
        exp_mem.delete();
        exp_rb.delete();
        @(negedge clk); #2;
        chk("rst_outputs",
            {making_request, mem_req, mem_we, mem_addr, mem_wdata, rb_wr_en, rb_wr_sel,
             rb_row, rb_col, rb_wr_data, wb_rd_sel, wb_rd_row, wb_rd_col}, 64'h0);
        rst = 1'b0;
        req0 = req_cycles;
        idle_cycles(10);
        chk("rst_no_mem_req", 64'(req_cycles - req0), 64'd0);

        // accepted normally after reset
        write_address        = 32'h40;
        write_request_width  = 17'd3;
        write_request_height = 9'd2;
        rd_buffer_sel        = 1'b1;
        clear_drain_area(32'h40);
        push_drain(32'h40, 2, 3, 2, 1'b0);
        mr0 = mr_cycles;
        start(1'b0, 1'b1);
        wait_done(200);
        chk("post_rst_mr_cycles", 64'(mr_cycles - mr0), 64'd12);
        chk("post_rst_queue_empty", 64'(exp_mem.size()), 64'd0);
        idle_cycles(2);

        // both again with random grant stalls
        stall_en = 1'b1;
        clear_drain_area(32'h40);
        push_drain(32'h40, 2, 3, 2, 1'b0);
        push_fill(32'h100, 2, 1'b0);
        rise0 = mr_rises;
        start(1'b1, 1'b1);
        wait_done(3000);
        chk("stall_mr_rises", 64'(mr_rises - rise0), 64'd1);
        chk("stall_queue_empty", 64'(exp_mem.size() + exp_rb.size()), 64'd0);
        check_drain_image();
        stall_en = 1'b0;
        idle_cycles(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
